// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: emits round keys 0..10 and shares an external SubWord unit.
// Optional abort input is compiled in with `define AES_KSC_ABORT_EN.
module aes_key_sched_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  output logic         sw_req_o,
  output logic [31:0]  sw_word_o,
  input  logic         sw_ack_i,
  input  logic [31:0]  sw_word_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         done_o
`ifdef AES_KSC_ABORT_EN
  ,
  input  logic         abort_i
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    SUB  = 2'd2,
    EXP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] w0, w1, w2, w3;
  logic [3:0]  idx;
  logic [7:0]  rcon;
  logic [31:0] sub;
  logic        done_q;
  logic        kill;

  logic [31:0] t, nw0, nw1, nw2, nw3;
  logic [7:0]  rcon_x;

`ifdef AES_KSC_ABORT_EN
  assign kill = abort_i && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i)    state_nxt = OUT;
      OUT:  if (rk_ready_i) state_nxt = (idx == 4'd10) ? IDLE : SUB;
      SUB:  if (sw_ack_i)   state_nxt = EXP;
      EXP:                  state_nxt = OUT;
      default:              state_nxt = IDLE;
    endcase
    // abort outranks both handshakes
    if (kill) state_nxt = IDLE;
  end

  always_comb begin
    t      = sub ^ {rcon, 24'h0};
    nw0    = w0 ^ t;
    nw1    = w1 ^ nw0;
    nw2    = w2 ^ nw1;
    nw3    = w3 ^ nw2;
    rcon_x = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w0     <= '0;
      w1     <= '0;
      w2     <= '0;
      w3     <= '0;
      idx    <= '0;
      rcon   <= 8'h01;
      sub    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            {w0, w1, w2, w3} <= key_i;
            idx              <= '0;
            rcon             <= 8'h01;
          end
        end
        OUT: begin
          if (rk_ready_i && (idx == 4'd10) && !kill) done_q <= 1'b1;
        end
        SUB: begin
          if (sw_ack_i && !kill) sub <= sw_word_i;
        end
        EXP: begin
          if (!kill) begin
            {w0, w1, w2, w3} <= {nw0, nw1, nw2, nw3};
            idx              <= idx + 4'd1;
            rcon             <= rcon_x;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o    = (state == IDLE);
  assign rk_valid_o = (state == OUT);
  assign sw_req_o   = (state == SUB);
  assign sw_word_o  = {w3[23:0], w3[31:24]};
  assign rk_o       = {w0, w1, w2, w3};
  assign rk_idx_o   = idx;
  assign done_o     = done_q;

endmodule
